uart_apb_regif: RTL

Parametrised APB3 slave that fronts a UART transmitter/receiver pair. It adds TX and RX FIFOs of configurable width and depth, plus status, control and overflow reporting, and drives a level interrupt. It sits between the APB fabric and the UART serialiser/deserialiser. On the UART side it uses valid/ready streams, replacing the single-byte `rdy`/`rdy_clr` exchange with buffered, flow-controlled transfer.

---
 rtl/uart_apb_pkg.sv | 31 +++
 rtl/uart_apb_fifo.sv | 51 +++++
 rtl/uart_apb_regif.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_apb_pkg.sv
// Shared register map, bit positions and the CTRL register layout for uart_apb_regif.
package uart_apb_pkg;

    // Byte offsets; only PADDR[3:2] takes part in the decode
    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;
    localparam logic [3:0] RSVD_OFS   = 4'hC;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVF      = 4;
    localparam int ST_RX_CNT   = 8;
    localparam int ST_TX_CNT   = 16;

    localparam int CT_RX_IE  = 0;
    localparam int CT_TX_IE  = 1;
    localparam int CT_OVF_IE = 2;
    localparam int CT_FLUSH  = 3;

    // Field order matches the CT_* bit positions (flush is the MSB)
    typedef struct packed {
        logic flush;
        logic ovf_ie;
        logic tx_ie;
        logic rx_ie;
    } ctrl_t;

endpackage

// File: rtl/uart_apb_fifo.sv
// Synchronous FIFO with count; a push into a full FIFO succeeds when a pop happens on the same edge.
module uart_apb_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // flush wins over any push or pop on the same edge
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_apb_regif.sv
// APB3 register front-end for a UART: TX/RX FIFOs, STATUS/CTRL registers, sticky overflow and level irq.
module uart_apb_regif
    import uart_apb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [31:0]       PADDR,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);

    ctrl_t             ctrl_q;
    logic              ovf;
    logic              access;
    logic [3:0]        ofs;
    logic              hit_data, wr_err, rd_err, rsvd;
    logic              tx_push, tx_pop, rx_pop, ovf_set;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_head;
    logic [31:0]       status;
    logic              unused_bits;

    assign unused_bits = ^{PADDR, PWDATA};

    assign access   = PSELx && PENABLE;
    assign ofs      = {PADDR[3:2], 2'b00};
    assign hit_data = access && (ofs == DATA_OFS);
    assign rsvd     = access && (ofs == RSVD_OFS);

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    // a full TX FIFO still takes a write when the transmitter drains one on the same edge
    assign wr_err   = hit_data && PWRITE && tx_full && !tx_pop;
    assign rd_err   = hit_data && !PWRITE && rx_empty;
    assign tx_push  = hit_data && PWRITE && !wr_err;
    assign rx_pop   = hit_data && !PWRITE && !rx_empty;
    assign ovf_set  = rx_valid && rx_full && !rx_pop;

    assign PREADY  = access && PRESETn;
    assign PSLVERR = PREADY && (wr_err || rd_err || rsvd);

    always_comb begin
        status                   = '0;
        status[ST_TX_EMPTY]      = tx_empty;
        status[ST_TX_FULL]       = tx_full;
        status[ST_RX_EMPTY]      = rx_empty;
        status[ST_RX_FULL]       = rx_full;
        status[ST_OVF]           = ovf;
        status[ST_RX_CNT +: 8]   = 8'(rx_count);
        status[ST_TX_CNT +: 8]   = 8'(tx_count);
    end

    always_comb begin
        PRDATA = '0;
        if (PREADY && !PWRITE) begin
            case (ofs)
                DATA_OFS:   PRDATA[DATA_W-1:0] = rx_head;
                STATUS_OFS: PRDATA = status;
                CTRL_OFS:   PRDATA[3:0] = ctrl_q;
                default:    PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q <= '0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq <= (ctrl_q.rx_ie && !rx_empty) || (ctrl_q.tx_ie && tx_empty) ||
                   (ctrl_q.ovf_ie && ovf);
            if (access && PWRITE && ofs == CTRL_OFS) ctrl_q <= ctrl_t'(PWDATA[3:0]);
            else                                      ctrl_q.flush <= 1'b0;
            // a new overflow beats a clear-write landing on the same edge
            if (ovf_set)                                                ovf <= 1'b1;
            else if (access && PWRITE && ofs == STATUS_OFS && PWDATA[ST_OVF]) ovf <= 1'b0;
        end
    end

    uart_apb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (ctrl_q.flush),
        .wdata (PWDATA[DATA_W-1:0]),
        .rdata (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    uart_apb_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_valid),
        .pop   (rx_pop),
        .flush (ctrl_q.flush),
        .wdata (rx_data),
        .rdata (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

endmodule
